// File: rtl/fire_sched_pkg.sv
// Shared types and helpers for the fire scheduler: FSM state enum, the IDLE index,
// and the round-robin search used by the pickers.
package fire_sched_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    QUIET = 2'd2
  } state_t;

  // Upper bound on N_SIGNALS supported by next_excited's fixed-width vector.
  localparam int unsigned MAX_SIGNALS = 64;

  function automatic int unsigned idle_idx(input int unsigned n);
    return n;
  endfunction

  // First set bit of vec[n-1:0] scanning upward from ptr+1 with wrap; n if none.
  // ptr must be < n.
  function automatic int unsigned next_excited(input logic [MAX_SIGNALS-1:0] vec,
                                               input int unsigned ptr,
                                               input int unsigned n);
    int unsigned idx;
    logic        found;
    next_excited = n;
    found        = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (!found && vec[idx[5:0]]) begin
        found        = 1'b1;
        next_excited = idx;
      end
    end
  endfunction

endpackage

// File: rtl/fire_rr_pick.sv
// Combinational rotate/priority pick: first set bit of vec after ptr (wrapping).
// With ptr = N_SIGNALS-1 it degenerates to a lowest-index pick.
module fire_rr_pick
  import fire_sched_pkg::*;
#(
  parameter int unsigned N_SIGNALS = 8,
  parameter int unsigned FIRE_BITS = $clog2(N_SIGNALS + 1)
) (
  input  logic [N_SIGNALS-1:0] vec,
  input  logic [FIRE_BITS-1:0] ptr,
  output logic                 valid,
  output logic [FIRE_BITS-1:0] index
);

  logic [MAX_SIGNALS-1:0] wide;
  int unsigned            pick;

  always_comb begin
    wide                 = '0;
    wide[N_SIGNALS-1:0]  = vec;
    pick                 = next_excited(wide, 32'(ptr), N_SIGNALS);
    valid                = (pick != idle_idx(N_SIGNALS));
    index                = FIRE_BITS'(pick);
  end

endmodule

// File: rtl/fire_scheduler.sv
// Bounded-fair fire index scheduler: forced > choice > round-robin > IDLE.
// Optional sticky fairness monitor: define FIRE_SCHEDULER_FAIRNESS_CHECK_EN.
module fire_scheduler
  import fire_sched_pkg::*;
#(
  parameter int unsigned N_SIGNALS = 8,
  parameter int unsigned FIRE_BITS = $clog2(N_SIGNALS + 1),
  parameter int unsigned LIMIT     = 4,
  parameter int unsigned CNT_W     = $clog2(LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SIGNALS-1:0] excited,
  input  logic [FIRE_BITS-1:0] choice,
  output logic [FIRE_BITS-1:0] fire,
  output logic                 fire_valid,
  output logic                 forced,
  output logic                 quiescent,
  output logic                 fair_err
);

  localparam logic [FIRE_BITS-1:0] IDLE     = FIRE_BITS'(idle_idx(N_SIGNALS));
  localparam logic [FIRE_BITS-1:0] LAST_IDX = FIRE_BITS'(N_SIGNALS - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(LIMIT);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       wait_cnt [N_SIGNALS];
  logic [FIRE_BITS-1:0]   last_fire;
  logic [N_SIGNALS-1:0]   starved, fire_hot;
  logic                   force_valid, rr_valid, choice_ok;
  logic [FIRE_BITS-1:0]   force_idx, rr_idx;

  always_comb begin
    starved   = '0;
    choice_ok = 1'b0;
    for (int unsigned i = 0; i < N_SIGNALS; i++) begin
      starved[i] = excited[i] && (wait_cnt[i] == CNT_MAX);
      if (choice == FIRE_BITS'(i) && excited[i]) choice_ok = 1'b1;
    end
  end

  fire_rr_pick #(.N_SIGNALS(N_SIGNALS), .FIRE_BITS(FIRE_BITS)) u_force_pick (
    .vec   (starved),
    .ptr   (LAST_IDX),
    .valid (force_valid),
    .index (force_idx)
  );

  fire_rr_pick #(.N_SIGNALS(N_SIGNALS), .FIRE_BITS(FIRE_BITS)) u_rr_pick (
    .vec   (excited),
    .ptr   (last_fire),
    .valid (rr_valid),
    .index (rr_idx)
  );

  always_comb begin
    state_nxt = state;
    fire      = IDLE;
    forced    = 1'b0;
    case (state)
      INIT:    state_nxt = RUN;
      RUN:     if (excited == '0) state_nxt = QUIET;
      QUIET:   if (excited != '0) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
    // reset is sampled here too so fire drops to IDLE the instant reset asserts
    if (reset && state != INIT) begin
      if (force_valid) begin
        fire   = force_idx;
        forced = 1'b1;
      end else if (choice_ok) begin
        fire = choice;
      end else if (rr_valid) begin
        fire = rr_idx;
      end
    end
  end

  assign fire_valid = (fire != IDLE);

  always_comb begin
    fire_hot = '0;
    for (int unsigned i = 0; i < N_SIGNALS; i++)
      fire_hot[i] = fire_valid && (fire == FIRE_BITS'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      last_fire <= LAST_IDX;
      quiescent <= 1'b0;
      for (int unsigned i = 0; i < N_SIGNALS; i++) wait_cnt[i] <= '0;
    end else begin
      state     <= state_nxt;
      quiescent <= (state != INIT) && (excited == '0);
      if (fire_valid) last_fire <= fire;
      for (int unsigned i = 0; i < N_SIGNALS; i++) begin
        if (!excited[i] || fire_hot[i])  wait_cnt[i] <= '0;
        else if (wait_cnt[i] != CNT_MAX) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

`ifdef FIRE_SCHEDULER_FAIRNESS_CHECK_EN
  localparam int unsigned          AGE_W   = $clog2(LIMIT + N_SIGNALS + 1);
  localparam logic [AGE_W-1:0]     AGE_MAX = AGE_W'(LIMIT + N_SIGNALS - 1);

  logic [AGE_W-1:0] age [N_SIGNALS];
  logic             starve_err, ghost_err;

  always_comb begin
    starve_err = 1'b0;
    ghost_err  = 1'b0;
    for (int unsigned i = 0; i < N_SIGNALS; i++) begin
      if (excited[i] && !fire_hot[i] && age[i] >= AGE_MAX) starve_err = 1'b1;
      if (fire_hot[i] && !excited[i])                      ghost_err  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fair_err <= 1'b0;
      for (int unsigned i = 0; i < N_SIGNALS; i++) age[i] <= '0;
    end else begin
      assert (!(starve_err || ghost_err));
      if (starve_err || ghost_err) fair_err <= 1'b1;
      for (int unsigned i = 0; i < N_SIGNALS; i++) begin
        if (!excited[i] || fire_hot[i]) age[i] <= '0;
        else if (age[i] != AGE_MAX)     age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  assign fair_err = 1'b0;
`endif

endmodule

// File: tb/tb_fire_scheduler.sv
// Scoreboard bench for fire_scheduler: directed scenarios then randomized traffic,
// expected outputs from a behavioural model of the selection/fairness rules.
module tb_fire_scheduler;

  localparam int N     = 8;
  localparam int LIMIT = 4;
  localparam int IDLE  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] excited = '0;
  logic [3:0] choice = '0;
  logic [3:0] fire;
  logic       fire_valid, forced, quiescent, fair_err;

  fire_scheduler #(.N_SIGNALS(8), .LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .excited    (excited),
    .choice     (choice),
    .fire       (fire),
    .fire_valid (fire_valid),
    .forced     (forced),
    .quiescent  (quiescent),
    .fair_err   (fair_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fire;
    bit forced;
    bit quiet;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   ncyc   = 0;

  // Reference model state: per-signal unfired-wait age, round-robin pointer, phase.
  int m_wait[N];
  int m_last;
  bit m_run;
  bit m_quiet;
  int m_fire;
  bit m_forced;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_last   = N - 1;
    m_run    = 0;
    m_quiet  = 0;
    m_fire   = IDLE;
    m_forced = 0;
  endfunction

  function automatic void m_select();
    m_fire   = IDLE;
    m_forced = 0;
    if (reset !== 1'b1 || !m_run) return;
    for (int i = 0; i < N; i++)
      if (excited[i] && m_wait[i] == LIMIT) begin
        m_fire   = i;
        m_forced = 1;
        return;
      end
    if (choice < 4'(N) && excited[choice[2:0]]) begin
      m_fire = int'(choice);
      return;
    end
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (excited[j]) begin
        m_fire = j;
        return;
      end
    end
  endfunction

  function automatic void m_step();
    if (reset !== 1'b1) begin
      m_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (!excited[i] || m_fire == i) m_wait[i] = 0;
      else if (m_wait[i] < LIMIT)     m_wait[i] = m_wait[i] + 1;
    end
    if (m_fire != IDLE) m_last = m_fire;
    m_quiet = m_run && (excited == 8'h00);
    m_run   = 1;
  endfunction

  task automatic cycle(input logic rst, input logic [7:0] ex, input logic [3:0] ch);
    @(posedge clk);
    m_step();
    #1;
    reset   = rst;
    excited = ex;
    choice  = ch;
    if (!rst) m_reset();
    m_select();
    sb.push_back('{fire: m_fire, forced: m_forced, quiet: m_quiet});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        ncyc++;
        e = sb.pop_front();
        chk("fire",       32'(fire),       32'(e.fire));
        chk("fire_valid", 32'(fire_valid), 32'(e.fire != IDLE));
        chk("forced",     32'(forced),     32'(e.forced));
        chk("quiescent",  32'(quiescent),  32'(e.quiet));
        chk("fair_err",   32'(fair_err),   32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

  initial begin
    logic       rst;
    logic [7:0] ex;
    m_reset();
    repeat (3) cycle(1'b0, 8'hFF, 4'd0);
    cycle(1'b1, 8'hFF, 4'd0);
    repeat (3) cycle(1'b1, 8'hFF, 4'($urandom_range(0, 15)));
    repeat (2) cycle(1'b1, 8'h00, 4'd0);
    cycle(1'b1, 8'h24, 4'd5);
    cycle(1'b1, 8'h24, 4'd3);
    cycle(1'b1, 8'h00, 4'd0);
    repeat (6) cycle(1'b1, 8'h03, 4'd0);
    cycle(1'b1, 8'h80, 4'd7);
    repeat (2) cycle(1'b1, 8'h09, 4'd9);
    repeat (2) cycle(1'b1, 8'h00, 4'd0);
    cycle(1'b1, 8'h10, 4'd9);
    cycle(1'b1, 8'h10, 4'd4);
    cycle(1'b1, 8'h00, 4'd0);
    repeat (3) cycle(1'b1, 8'h03, 4'd0);
    repeat (2) cycle(1'b0, 8'h03, 4'd0);
    repeat (7) cycle(1'b1, 8'h03, 4'd0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 79) != 0);
      case ($urandom_range(0, 5))
        0:       ex = 8'h00;
        1:       ex = 8'(1 << $urandom_range(0, 7));
        default: ex = 8'($urandom);
      endcase
      cycle(rst, ex, 4'($urandom_range(0, 15)));
    end
    cycle(1'b1, 8'h00, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fire_scheduler.md
Name: fire_scheduler

Overview:
- Drives the `fire` index of a synchronous model of an asynchronous circuit.
- Each cycle it selects at most one excited signal, i.e. a signal whose `_precap` value differs from its registered value.
- The selected index is the only capture DFF/latch enabled that cycle.
- Replaces the unbound `fire` register with a constrained, bounded-fair choice: the formal tool still steers the interleaving through `choice`, but no excited signal can starve.

Parameters:
- N_SIGNALS, 8, number of fireable signals (inputs + stateful outputs/internals); indices 0..N_SIGNALS-1.
- FIRE_BITS, $clog2(N_SIGNALS+1), width of fire/choice; value N_SIGNALS is reserved as IDLE.
- LIMIT, 4, consecutive excited-but-unfired cycles after which a signal is forced.
- CNT_W, $clog2(LIMIT+1), width of each wait counter.

Ports:
- clk  in  1  model clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- excited  in  N_SIGNALS  bit i=1 when signal i's precap differs from its Q.
- choice  in  FIRE_BITS  free nondeterministic request from the formal tool/bench.
- fire  out  FIRE_BITS  index enabled this cycle; IDLE (N_SIGNALS) means none.
- fire_valid  out  1  fire != IDLE.
- forced  out  1  current fire comes from the fairness override.
- quiescent  out  1  registered; no signal excited for at least one full cycle.
- fair_err  out  1  sticky error (only with the optional feature; tied 0 otherwise).

Behaviour:
- States: INIT, RUN, QUIET (2-bit enum).
- Reset asserted (async): state=INIT, all wait_cnt=0, last_fire=N_SIGNALS-1, quiescent=0, fair_err=0.
- While reset is asserted or state==INIT: fire=IDLE, fire_valid=0, forced=0.
- INIT -> RUN on the first clk edge after reset deasserts. INIT gives one idle cycle for ST/RS initial values to settle.
- fire, fire_valid and forced are combinational from registered state plus excited/choice, with zero latency. They enable capture on the same edge.
- Selection in RUN/QUIET, in priority order:
  1. Forced: any i with excited[i] && wait_cnt[i]==LIMIT; pick the lowest such i; forced=1.
  2. Choice: choice<N_SIGNALS && excited[choice]; fire=choice.
  3. Round-robin: first i with excited[i], scanning upward from last_fire+1 and wrapping modulo N_SIGNALS.
  4. Otherwise fire=IDLE.
- Out-of-range choice (>=N_SIGNALS), or a choice that is not excited, falls through to round-robin. It is never IDLE if something is excited.
- Fairness bound: an excited signal fires within LIMIT+N_SIGNALS-1 cycles of becoming continuously excited.
- wait_cnt[i] update per edge:
  - Cleared if !excited[i] or fire==i.
  - Otherwise incremented, saturating at LIMIT.
  - If excited drops in the same cycle the counter would reach LIMIT, it clears; clearing wins.
- last_fire updates to fire only when fire_valid.
- RUN -> QUIET when excited==0 at an edge; quiescent=1 from the next cycle.
- QUIET -> RUN when excited!=0 at an edge; quiescent=0 from the next cycle. Selection is active in QUIET, so there is no lost cycle.
- Reset mid-operation: fire goes IDLE immediately (async); counters and pointer are reinitialised.

Optional Feature:
- Macro: FIRE_SCHEDULER_FAIRNESS_CHECK_EN.
- Defined:
  - Per-signal age counters of width $clog2(LIMIT+N_SIGNALS+1).
  - fair_err sets (sticky until reset) if any excited signal remains unfired for more than LIMIT+N_SIGNALS-1 consecutive cycles.
  - fair_err also sets if fire_valid occurs with !excited[fire].
  - Also emits an immediate assertion on the same conditions for the formal flow.
- Undefined: no age counters; fair_err tied 0.

Decomposition:
- Package fire_sched_pkg holds:
  - state enum (INIT, RUN, QUIET);
  - function idle_idx(N) returning N;
  - round-robin search function next_excited(vec, ptr).
- One sub-module, fire_rr_pick, is natural: combinational rotate/priority-encode of excited from last_fire+1 → {valid, index}. It is reused for the forced path with ptr=N_SIGNALS-1 (lowest-index pick).

Test Plan:
- Reset: reset=0 for 3 cycles, then 1 with excited=8'hFF → fire=8 (IDLE) during reset and the INIT cycle; first valid fire on the next cycle.
- Choice honoured: excited=8'b0010_0100, choice=5 → fire=5, forced=0; choice=3 → round-robin from last_fire=5 → fire=2.
- Starvation override: excited=8'b0000_0011, choice held at 0 → fire=0 for LIMIT=4 cycles, then fire=1 with forced=1; wait_cnt[1] clears.
- Wrap-around: last_fire=7, excited=8'b0000_1001, choice=9 (out of range) → fire=0; next cycle fire=3.
- Quiescence: excited=0 for 2 cycles → fire=8, fire_valid=0, quiescent=1 from the 2nd cycle; excited=8'h10 → fire=4 the same cycle, quiescent=0 the next.
- Reset mid-run (with FIRE_SCHEDULER_FAIRNESS_CHECK_EN): assert reset while wait_cnt[1]=3 → fire=IDLE async, fair_err=0, counters=0 after release. Separately, force fire=2 while excited[2]=0 via a bind mutation → fair_err=1 and stays set.
